stopwatch_core: RTL

Millisecond-resolution stopwatch counter for the Timer design. Sits directly downstream of the millisecond clock divider: it samples the divider's `msclk` output in the `clk` domain and turns each rising edge into one millisecond of elapsed time. It provides start/stop/clear control and BCD minute/second/millisecond outputs for the display stage.

---
 rtl/stopwatch_core_if.sv | 51 +++++
 rtl/stopwatch_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core_if.sv
// -----------------------------------------------------------------------------
// stopwatch_core_if
//   Signal bundle between the stopwatch control/display side and stopwatch_core.
//
//   Inputs to the core (driven by the master side):
//     msclk       divider output level; each rising edge is one 1 ms tick
//     start_stop  debounced level; each rising edge toggles run/pause
//     clear       debounced level; each rising edge zeroes time and stops
//   Outputs from the core (driven by the slave side):
//     running     1 while counting
//     ms_bcd      milliseconds, 3 BCD digits (hundreds in [11:8])
//     sec_bcd     seconds, 2 BCD digits
//     min_bcd     minutes, 2 BCD digits
//     sec_pulse   one-cycle pulse whenever the seconds value changes
//     wrapped     sticky roll-over flag
// -----------------------------------------------------------------------------
interface stopwatch_core_if;
  logic        msclk;
  logic        start_stop;
  logic        clear;
  logic        running;
  logic [11:0] ms_bcd;
  logic [7:0]  sec_bcd;
  logic [7:0]  min_bcd;
  logic        sec_pulse;
  logic        wrapped;

  modport master (
    output msclk,
    output start_stop,
    output clear,
    input  running,
    input  ms_bcd,
    input  sec_bcd,
    input  min_bcd,
    input  sec_pulse,
    input  wrapped
  );

  modport slave (
    input  msclk,
    input  start_stop,
    input  clear,
    output running,
    output ms_bcd,
    output sec_bcd,
    output min_bcd,
    output sec_pulse,
    output wrapped
  );
endinterface

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//   Millisecond-resolution stopwatch. Rising edges of msclk (sampled in the clk
//   domain) each add one millisecond to a BCD cascade mm:ss.mmm. start_stop
//   edges toggle run/pause, clear edges zero the time and return to IDLE.
//   All outputs come straight from registers.
//
//   Parameters:
//     MIN_MAX     highest minute value before roll-over (1..99)
//   Ports:
//     clk         system clock, rising edge
//     reset       asynchronous, active-low
//     bus         stopwatch_core_if.slave (see interface header)
// -----------------------------------------------------------------------------
module stopwatch_core #(
  parameter int unsigned MIN_MAX = 59
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_core_if.slave  bus
);

  // Minute limit split into BCD digits at elaboration time.
  localparam logic [3:0] MAX_TENS  = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_UNITS = 4'(MIN_MAX % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_state_n;

  // "Previous" copies for edge detection; reset to 1 so that an input held
  // high through reset release never produces an edge.
  logic       r_msclk_prev;
  logic       r_ss_prev;
  logic       r_clr_prev;

  logic       w_tick;
  logic       w_ss_edge;
  logic       w_clr_edge;
  logic       w_count;

  // Time digits: hundreds/tens/units of ms, tens/units of s and min.
  logic [3:0] r_ms_h;
  logic [3:0] r_ms_t;
  logic [3:0] r_ms_u;
  logic [3:0] r_sec_t;
  logic [3:0] r_sec_u;
  logic [3:0] r_min_t;
  logic [3:0] r_min_u;

  logic [3:0] w_ms_h_n;
  logic [3:0] w_ms_t_n;
  logic [3:0] w_ms_u_n;
  logic [3:0] w_sec_t_n;
  logic [3:0] w_sec_u_n;
  logic [3:0] w_min_t_n;
  logic [3:0] w_min_u_n;

  // Carry chain: each flag means "this digit and all lower ones roll over".
  logic       w_c_ms_u;
  logic       w_c_ms_t;
  logic       w_c_ms;
  logic       w_c_sec_u;
  logic       w_c_sec;
  logic       w_c_min_u;
  logic       w_wrap;

  logic       r_running;
  logic       r_sec_pulse;
  logic       r_wrapped;

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_msclk_prev <= 1'b1;
      r_ss_prev    <= 1'b1;
      r_clr_prev   <= 1'b1;
    end else begin
      r_msclk_prev <= bus.msclk;
      r_ss_prev    <= bus.start_stop;
      r_clr_prev   <= bus.clear;
    end
  end

  assign w_tick     = bus.msclk      & ~r_msclk_prev;
  assign w_ss_edge  = bus.start_stop & ~r_ss_prev;
  assign w_clr_edge = bus.clear      & ~r_clr_prev;

  // A tick counts only in the registered RUN state; a start edge in the same
  // cycle therefore never counts, while a stop edge still lets the tick in.
  assign w_count = (r_state == RUN) && w_tick && !w_clr_edge;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_running <= (w_state_n == RUN);
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (w_clr_edge) begin
      w_state_n = IDLE;
    end else if (w_ss_edge) begin
      case (r_state)
        IDLE:    w_state_n = RUN;
        RUN:     w_state_n = PAUSE;
        PAUSE:   w_state_n = RUN;
        default: w_state_n = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // BCD cascade next values (one millisecond later)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_c_ms_u  = (r_ms_u == 4'd9);
    w_c_ms_t  = w_c_ms_u && (r_ms_t == 4'd9);
    w_c_ms    = w_c_ms_t && (r_ms_h == 4'd9);
    w_c_sec_u = w_c_ms && (r_sec_u == 4'd9);
    w_c_sec   = w_c_sec_u && (r_sec_t == 4'd5);
    w_c_min_u = w_c_sec && (r_min_u == 4'd9);
    w_wrap    = w_c_sec && (r_min_t == MAX_TENS) && (r_min_u == MAX_UNITS);

    w_ms_u_n  = w_c_ms_u  ? '0 : r_ms_u + 4'd1;

    w_ms_t_n  = r_ms_t;
    if (w_c_ms_t)      w_ms_t_n = '0;
    else if (w_c_ms_u) w_ms_t_n = r_ms_t + 4'd1;

    w_ms_h_n  = r_ms_h;
    if (w_c_ms)        w_ms_h_n = '0;
    else if (w_c_ms_t) w_ms_h_n = r_ms_h + 4'd1;

    w_sec_u_n = r_sec_u;
    if (w_c_sec_u)     w_sec_u_n = '0;
    else if (w_c_ms)   w_sec_u_n = r_sec_u + 4'd1;

    w_sec_t_n = r_sec_t;
    if (w_c_sec)        w_sec_t_n = '0;
    else if (w_c_sec_u) w_sec_t_n = r_sec_t + 4'd1;

    // The minute limit need not end in 9, so wrap overrides the units carry.
    w_min_u_n = r_min_u;
    if (w_wrap || w_c_min_u) w_min_u_n = '0;
    else if (w_c_sec)        w_min_u_n = r_min_u + 4'd1;

    w_min_t_n = r_min_t;
    if (w_wrap)         w_min_t_n = '0;
    else if (w_c_min_u) w_min_t_n = r_min_t + 4'd1;
  end

  // ---------------------------------------------------------------------------
  // Time registers, seconds pulse and wrap flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ms_h      <= '0;
      r_ms_t      <= '0;
      r_ms_u      <= '0;
      r_sec_t     <= '0;
      r_sec_u     <= '0;
      r_min_t     <= '0;
      r_min_u     <= '0;
      r_sec_pulse <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      r_sec_pulse <= 1'b0;
      if (w_clr_edge) begin
        r_ms_h    <= '0;
        r_ms_t    <= '0;
        r_ms_u    <= '0;
        r_sec_t   <= '0;
        r_sec_u   <= '0;
        r_min_t   <= '0;
        r_min_u   <= '0;
        r_wrapped <= 1'b0;
      end else if (w_count) begin
        r_ms_h      <= w_ms_h_n;
        r_ms_t      <= w_ms_t_n;
        r_ms_u      <= w_ms_u_n;
        r_sec_t     <= w_sec_t_n;
        r_sec_u     <= w_sec_u_n;
        r_min_t     <= w_min_t_n;
        r_min_u     <= w_min_u_n;
        // Seconds change on every millisecond carry, including the wrap.
        r_sec_pulse <= w_c_ms;
        if (w_wrap) r_wrapped <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.running   = r_running;
  assign bus.ms_bcd    = {r_ms_h, r_ms_t, r_ms_u};
  assign bus.sec_bcd   = {r_sec_t, r_sec_u};
  assign bus.min_bcd   = {r_min_t, r_min_u};
  assign bus.sec_pulse = r_sec_pulse;
  assign bus.wrapped   = r_wrapped;

endmodule
